// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams operand bit pairs LSB-first through a
// 1-bit full_adder cell, recirculating its carry, and presents the registered result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   s_sr_q, s_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_s, fa_cout;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          s_sr_d  = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        // Result registers only move on the final bit so partial sums stay hidden.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == ADD);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed vector table, hand sequences for
// ignored starts and mid-run reset, random ops and a WIDTH=4 streaming sweep.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] st4;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_o(st8)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state_o(st4)
  );

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: {cout,sum} is simply the integer sum, truncated to WIDTH+1 bits.
  function automatic logic [32:0] model(input int a, input int b, input int c, input int w);
    int unsigned t;
    t = a + b + c;
    return 33'(t & ((1 << (w + 1)) - 1));
  endfunction

  // One WIDTH=8 operation; expected result must already be in exp_q.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input bit inject);
    int cyc;
    int busy_cnt;
    logic [32:0] e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = ~cin;
    cyc = 0;
    busy_cnt = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) busy_cnt++;
      if (inject && (cyc == 2 || cyc == 7)) begin
        start8 = 1'b1;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc++;
    end
    check("latency8", 64'(cyc), 64'd8);
    check("busy_cycles8", 64'(busy_cnt), 64'd8);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
    check("result8", {55'd0, cout8, sum8}, {55'd0, e[8:0]});
    @(posedge clk); #1;
    check("done_one_cycle8", {63'd0, done8}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cnt;
    int held_bad;
    int dones;
    int cyc;
    int last;
    int idx;
    int ra, rb, rc;
    logic [32:0] e;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    // Clock/reset
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #22;
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_done8", {63'd0, done8}, 64'd0);
    check("rst_result8", {55'd0, cout8, sum8}, 64'd0);
    check("rst_busy4", {63'd0, busy4}, 64'd0);
    check("rst_result4", {59'd0, cout4, sum4}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({24'd0, vecs[i].exp_cout, vecs[i].exp_sum});
      do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
    end

    // Starts during busy and DONE are ignored; the result then holds in IDLE
    exp_q.push_back({24'd0, 1'b0, 8'h4B});
    do_op8(8'h3C, 8'h0F, 1'b0, 1'b1);
    done_cnt = 0;
    held_bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done8) done_cnt++;
      if ({cout8, sum8} !== 9'h04B) held_bad++;
    end
    check("ignored_start_extra_done", 64'(done_cnt), 64'd0);
    check("sum_hold_idle", 64'(held_bad), 64'd0);

    // Reset in the middle of a run
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy8}, 64'd0);
    check("midrst_done", {63'd0, done8}, 64'd0);
    check("midrst_result", {55'd0, cout8, sum8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) done_cnt++;
    end
    check("midrst_no_resume", 64'(done_cnt), 64'd0);
    exp_q.push_back({24'd0, 1'b0, 8'h30});
    do_op8(8'h10, 8'h20, 1'b0, 1'b0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rc = int'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rc, 8));
      do_op8(8'(ra), 8'(rb), 1'(rc), 1'b0);
    end

    // WIDTH=4 exhaustive sweep, start held high
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    exp_q.push_back(model(0, 0, 0, 4));
    start4 = 1'b1;
    dones = 0;
    cyc = 0;
    last = -1;
    while (dones < 512 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (done4) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
        check("result4", {59'd0, cout4, sum4}, {59'd0, e[4:0]});
        if (last >= 0) check("period4", 64'(cyc - last), 64'd6);
        last = cyc;
        dones++;
        if (dones < 512) begin
          idx = dones;
          a4 = idx[3:0];
          b4 = idx[7:4];
          cin4 = idx[8];
          exp_q.push_back(model(int'(idx[3:0]), int'(idx[7:4]), int'(idx[8]), 4));
        end else begin
          start4 = 1'b0;
        end
      end
    end
    check("sweep_count4", 64'(dones), 64'd512);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
